// File: rtl/light_monitor.sv
// Receive-side checker for the two-road lamp interface: registers the six lamps, decodes a
// phase code and keeps sticky lamp/sequence/timing faults plus a saturating event counter.
module light_monitor #(
  parameter int T_G1 = 40,
  parameter int T_Y1 = 5,
  parameter int T_G2 = 30,
  parameter int T_Y2 = 5,
  parameter int CW   = 8
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          LR1,
  input  logic          LY1,
  input  logic          LG1,
  input  logic          LR2,
  input  logic          LY2,
  input  logic          LG2,
  input  logic          clr,
  output logic [2:0]    phase,
  output logic          fault_lamp,
  output logic          fault_seq,
  output logic          fault_time,
  output logic          fault,
  output logic [CW-1:0] err_count
);

  localparam logic [2:0]    PH_NONE = 3'd0;
  localparam logic [2:0]    PH_G1R2 = 3'd1;
  localparam logic [2:0]    PH_Y1R2 = 3'd2;
  localparam logic [2:0]    PH_R1G2 = 3'd3;
  localparam logic [2:0]    PH_R1Y2 = 3'd4;
  localparam logic [2:0]    PH_INV  = 3'd7;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic {ST_SYNC = 1'b0, ST_TRACK = 1'b1} state_t;

  function automatic logic [2:0] succ(input logic [2:0] ph);
    case (ph)
      PH_G1R2: succ = PH_Y1R2;
      PH_Y1R2: succ = PH_R1G2;
      PH_R1G2: succ = PH_R1Y2;
      PH_R1Y2: succ = PH_G1R2;
      default: succ = PH_NONE;
    endcase
  endfunction

  function automatic logic [CW-1:0] t_req(input logic [2:0] ph);
    case (ph)
      PH_G1R2: t_req = CW'(T_G1);
      PH_Y1R2: t_req = CW'(T_Y1);
      PH_R1G2: t_req = CW'(T_G2);
      PH_R1Y2: t_req = CW'(T_Y2);
      default: t_req = {CW{1'b0}};
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] ph);
    case (ph)
      PH_G1R2, PH_Y1R2, PH_R1G2, PH_R1Y2: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  logic [5:0]    lamps_r;
  logic          lamps_vld_r;
  logic [2:0]    phase_now_s;
  logic [2:0]    phase_r;
  logic [CW-1:0] dur_r;
  state_t        state_r;
  state_t        state_nxt_s;
  logic          transition_s;
  logic          lamp_ev_s;
  logic          seq_ev_s;
  logic          time_ev_s;
  logic          fault_lamp_r;
  logic          fault_seq_r;
  logic          fault_time_r;
  logic          fault_r;
  logic [CW-1:0] err_count_r;
  logic          fault_lamp_nxt_s;
  logic          fault_seq_nxt_s;
  logic          fault_time_nxt_s;
  logic [CW-1:0] err_count_base_s;
  logic [CW-1:0] err_count_nxt_s;

  // Stage 1: lamp capture; valid flag keeps stage 2 idle until real lamp data is held
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      lamps_r     <= 6'b000000;
      lamps_vld_r <= 1'b0;
    end else begin
      lamps_r     <= {LR1, LY1, LG1, LR2, LY2, LG2};
      lamps_vld_r <= 1'b1;
    end
  end

  // Lamp pattern to phase code
  always_comb begin
    case (lamps_r)
      6'b001_100: phase_now_s = PH_G1R2;
      6'b010_100: phase_now_s = PH_Y1R2;
      6'b100_001: phase_now_s = PH_R1G2;
      6'b100_010: phase_now_s = PH_R1Y2;
      default:    phase_now_s = PH_INV;
    endcase
  end

  assign transition_s = lamps_vld_r && (phase_now_s != phase_r);

  // Stage 2: phase register and saturating duration counter
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      phase_r <= PH_NONE;
      dur_r   <= {CW{1'b0}};
    end else if (lamps_vld_r) begin
      phase_r <= phase_now_s;
      if (transition_s) begin
        dur_r <= CNT_ONE;
      end else if (dur_r != CNT_MAX) begin
        dur_r <= dur_r + CNT_ONE;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state_r <= ST_SYNC;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: INVALID resynchronises, leaving a legal phase starts tracking
  always_comb begin
    state_nxt_s = state_r;
    if (transition_s) begin
      if (phase_now_s == PH_INV) begin
        state_nxt_s = ST_SYNC;
      end else if (is_legal(phase_r)) begin
        state_nxt_s = ST_TRACK;
      end else begin
        state_nxt_s = state_r;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM outputs: fault events; duration is only trusted once tracking
  always_comb begin
    lamp_ev_s = transition_s && (phase_now_s == PH_INV);
    seq_ev_s  = 1'b0;
    time_ev_s = 1'b0;
    if (transition_s && (phase_now_s != PH_INV) && is_legal(phase_r)) begin
      seq_ev_s  = (phase_now_s != succ(phase_r));
      time_ev_s = (state_r == ST_TRACK) && (dur_r != t_req(phase_r));
    end else begin
      seq_ev_s  = 1'b0;
      time_ev_s = 1'b0;
    end
  end

  // clr wipes the old state but events of the same cycle still land
  always_comb begin
    fault_lamp_nxt_s = (clr ? 1'b0 : fault_lamp_r) | lamp_ev_s;
    fault_seq_nxt_s  = (clr ? 1'b0 : fault_seq_r)  | seq_ev_s;
    fault_time_nxt_s = (clr ? 1'b0 : fault_time_r) | time_ev_s;
    err_count_base_s = clr ? {CW{1'b0}} : err_count_r;
    if ((lamp_ev_s || seq_ev_s || time_ev_s) && (err_count_base_s != CNT_MAX)) begin
      err_count_nxt_s = err_count_base_s + CNT_ONE;
    end else begin
      err_count_nxt_s = err_count_base_s;
    end
  end

  // Sticky flags, summary fault and event counter
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      fault_lamp_r <= 1'b0;
      fault_seq_r  <= 1'b0;
      fault_time_r <= 1'b0;
      fault_r      <= 1'b0;
      err_count_r  <= {CW{1'b0}};
    end else begin
      fault_lamp_r <= fault_lamp_nxt_s;
      fault_seq_r  <= fault_seq_nxt_s;
      fault_time_r <= fault_time_nxt_s;
      fault_r      <= fault_lamp_nxt_s | fault_seq_nxt_s | fault_time_nxt_s;
      err_count_r  <= err_count_nxt_s;
    end
  end

  assign phase      = phase_r;
  assign fault_lamp = fault_lamp_r;
  assign fault_seq  = fault_seq_r;
  assign fault_time = fault_time_r;
  assign fault      = fault_r;
  assign err_count  = err_count_r;

endmodule
